// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared types for the stopwatch lap/split controller.
// Display-source states and the packed three-digit lap word.
package stopwatch_lap_ctrl_pkg;

  localparam int LAP_W = 12;

  typedef enum logic [1:0] {
    ST_LIVE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_RECALL = 2'b10
  } state_e;

  typedef logic [LAP_W-1:0] lap_t;

  function automatic lap_t pack_lap(
    input logic [3:0] d2,
    input logic [3:0] d1,
    input logic [3:0] d0
  );
    return {d2, d1, d0};
  endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_fnd.sv
// FND decoder: one BCD digit to an active-high gfedcba pattern.
// Codes above 9 blank the digit.
module stopwatch_lap_ctrl_fnd (
  input  logic [3:0] i_Num,
  output logic [6:0] o_Seg
);

  always_comb begin
    o_Seg = 7'h00;
    case (i_Num)
      4'd0:    o_Seg = 7'h3F;
      4'd1:    o_Seg = 7'h06;
      4'd2:    o_Seg = 7'h5B;
      4'd3:    o_Seg = 7'h4F;
      4'd4:    o_Seg = 7'h66;
      4'd5:    o_Seg = 7'h6D;
      4'd6:    o_Seg = 7'h7D;
      4'd7:    o_Seg = 7'h07;
      4'd8:    o_Seg = 7'h7F;
      4'd9:    o_Seg = 7'h6F;
      default: o_Seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Lap/split controller: captures live BCD time on lap presses,
// holds new laps on the display and lets the user step through them.
module stopwatch_lap_ctrl
  import stopwatch_lap_ctrl_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_CLK = 100_000_000*2 - 1,
  parameter int HOLD_W   = 28
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fLap,
  input  logic       i_fView,
  input  logic       i_fClr,
  input  logic       i_fRun,
  input  logic [3:0] i_Sec0,
  input  logic [3:0] i_Sec1,
  input  logic [3:0] i_Sec2,
  output logic [6:0] o_Disp0,
  output logic [6:0] o_Disp1,
  output logic [6:0] o_Disp2,
  output logic [3:0] o_LapCnt,
  output logic [2:0] o_LapIdx,
  output logic       o_fFull,
  output logic       o_fView
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_CLK);

  state_e state_q, state_d;

  logic [3:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [2:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic lap_prev_q, lap_prev_d;
  logic view_prev_q, view_prev_d;
  logic clr_prev_q, clr_prev_d;

  lap_t mem_q [DEPTH];
  lap_t mem_d [DEPTH];

  logic raw_lap, raw_view;
  logic ev_clr, ev_lap, ev_view;
  logic full, can_store, store;
  logic idx_last;

  lap_t live_word, disp_word;

  // Press = pin low now while the registered copy is still high.
  assign raw_lap  = ~i_fLap & lap_prev_q;
  assign raw_view = ~i_fView & view_prev_q;
  assign ev_clr   = ~i_fClr & clr_prev_q;
  assign ev_lap   = raw_lap & ~ev_clr;
  assign ev_view  = raw_view & ~ev_clr & ~raw_lap;

  assign full      = (cnt_q == DEPTH_C);
  assign can_store = ev_lap & i_fRun & ~full;
  assign store     = can_store & (state_q != ST_RECALL);
  assign idx_last  = (({1'b0, idx_q} + 4'd1) >= cnt_q);

  assign live_word = pack_lap(i_Sec2, i_Sec1, i_Sec0);

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_LIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LIVE: begin
        if (ev_clr)
          state_d = ST_LIVE;
        else if (can_store)
          state_d = ST_HOLD;
        else if (ev_view && cnt_q != 4'd0)
          state_d = ST_RECALL;
      end
      ST_HOLD: begin
        if (ev_clr)
          state_d = ST_LIVE;
        else if (can_store)
          state_d = ST_HOLD;
        else if (ev_view)
          state_d = ST_RECALL;
        else if (hold_q == HOLD_END)
          state_d = ST_LIVE;
      end
      ST_RECALL: begin
        if (ev_clr)
          state_d = ST_LIVE;
        else if (ev_view && idx_last)
          state_d = ST_LIVE;
      end
      default: state_d = ST_LIVE;
    endcase
  end

  // Display source and view flag
  always_comb begin
    disp_word = live_word;
    o_fView   = 1'b0;
    unique case (state_q)
      ST_LIVE:   disp_word = live_word;
      ST_HOLD:   disp_word = mem_q[ptr_q - PTR_ONE];
      ST_RECALL: begin
        disp_word = mem_q[idx_q[PTR_W-1:0]];
        o_fView   = 1'b1;
      end
      default:   disp_word = live_word;
    endcase
  end

  // Datapath next values
  always_comb begin
    lap_prev_d  = i_fLap;
    view_prev_d = i_fView;
    clr_prev_d  = i_fClr;

    cnt_d = cnt_q;
    ptr_d = ptr_q;
    mem_d = mem_q;

    if (ev_clr) begin
      cnt_d = 4'd0;
      ptr_d = '0;
    end else if (store) begin
      cnt_d = cnt_q + 4'd1;
      ptr_d = ptr_q + PTR_ONE;
      mem_d[ptr_q] = live_word;
    end

    if (state_q == ST_HOLD && !store)
      hold_d = hold_q + HOLD_W'(1);
    else
      hold_d = '0;

    idx_d = idx_q;
    if (ev_clr)
      idx_d = 3'd0;
    else if (state_q == ST_RECALL && ev_view)
      idx_d = idx_last ? 3'd0 : idx_q + 3'd1;
    else if (state_q != ST_RECALL && state_d == ST_RECALL)
      idx_d = 3'd0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt_q       <= 4'd0;
      ptr_q       <= '0;
      idx_q       <= 3'd0;
      hold_q      <= '0;
      lap_prev_q  <= 1'b1;
      view_prev_q <= 1'b1;
      clr_prev_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      lap_prev_q  <= lap_prev_d;
      view_prev_q <= view_prev_d;
      clr_prev_q  <= clr_prev_d;
      mem_q       <= mem_d;
    end
  end

  assign o_LapCnt = cnt_q;
  assign o_LapIdx = idx_q;
  assign o_fFull  = full;

  stopwatch_lap_ctrl_fnd u_fnd0 (
    .i_Num (disp_word[3:0]),
    .o_Seg (o_Disp0)
  );

  stopwatch_lap_ctrl_fnd u_fnd1 (
    .i_Num (disp_word[7:4]),
    .o_Seg (o_Disp1)
  );

  stopwatch_lap_ctrl_fnd u_fnd2 (
    .i_Num (disp_word[11:8]),
    .o_Seg (o_Disp2)
  );

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl with an expectation queue
// drained against the outputs shortly after each clock edge.
module tb_stopwatch_lap_ctrl;

  localparam int F_CNT  = 0;
  localparam int F_IDX  = 1;
  localparam int F_FULL = 2;
  localparam int F_VIEW = 3;
  localparam int F_DISP = 4;

  typedef struct {
    string       tag;
    int          fld;
    logic [20:0] v;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       f_lap, f_view, f_clr, f_run;
  logic [3:0] sec0, sec1, sec2;
  logic [6:0] disp0, disp1, disp2;
  logic [3:0] lap_cnt;
  logic [2:0] lap_idx;
  logic       f_full, f_viewo;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  stopwatch_lap_ctrl #(
    .DEPTH    (4),
    .HOLD_CLK (9),
    .HOLD_W   (8)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst_n),
    .i_fLap   (f_lap),
    .i_fView  (f_view),
    .i_fClr   (f_clr),
    .i_fRun   (f_run),
    .i_Sec0   (sec0),
    .i_Sec1   (sec1),
    .i_Sec2   (sec2),
    .o_Disp0  (disp0),
    .o_Disp1  (disp1),
    .o_Disp2  (disp2),
    .o_LapCnt (lap_cnt),
    .o_LapIdx (lap_idx),
    .o_fFull  (f_full),
    .o_fView  (f_viewo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] fd(input int d2, input int d1, input int d0);
    return {seg(d2), seg(d1), seg(d0)};
  endfunction

  function automatic logic [20:0] observe(input int fld);
    case (fld)
      F_CNT:  return {17'd0, lap_cnt};
      F_IDX:  return {18'd0, lap_idx};
      F_FULL: return {20'd0, f_full};
      F_VIEW: return {20'd0, f_viewo};
      default: return {disp2, disp1, disp0};
    endcase
  endfunction

  task automatic push(input string tag, input int fld, input logic [20:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [20:0] obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.fld);
      total++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s: got %0h want %0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sec(input int d2, input int d1, input int d0);
    sec2 = 4'(d2);
    sec1 = 4'(d1);
    sec0 = 4'(d0);
  endtask

  initial begin
    rst_n  = 1'b0;
    f_lap  = 1'b1;
    f_view = 1'b1;
    f_clr  = 1'b1;
    f_run  = 1'b0;
    set_sec(4, 5, 6);

    // 1. reset
    repeat (3) tick();
    push("rst_cnt", F_CNT, 21'd0);
    push("rst_full", F_FULL, 21'd0);
    push("rst_view", F_VIEW, 21'd0);
    push("rst_idx", F_IDX, 21'd0);
    push("rst_disp", F_DISP, fd(4, 5, 6));
    check();
    rst_n = 1'b1;
    tick();
    push("rel_cnt", F_CNT, 21'd0);
    push("rel_disp", F_DISP, fd(4, 5, 6));
    check();

    // 2. single lap and hold window
    f_run = 1'b1;
    set_sec(1, 2, 3);
    f_lap = 1'b0;
    push("lap1_cnt", F_CNT, 21'd1);
    push("lap1_disp", F_DISP, fd(1, 2, 3));
    tick();
    check();
    f_lap = 1'b1;
    set_sec(7, 8, 9);
    for (int k = 1; k < 10; k++) begin
      push("hold_disp", F_DISP, fd(1, 2, 3));
      tick();
      check();
    end
    push("hold_end_disp", F_DISP, fd(7, 8, 9));
    push("hold_end_view", F_VIEW, 21'd0);
    tick();
    check();

    // 3. clear, then fill past capacity
    f_clr = 1'b0;
    push("clr_cnt", F_CNT, 21'd0);
    tick();
    check();
    f_clr = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      set_sec(k, 0, k);
      f_lap = 1'b0;
      push("fill_cnt", F_CNT, 21'((k > 4) ? 4 : k));
      push("fill_full", F_FULL, 21'((k >= 4) ? 1 : 0));
      tick();
      check();
      f_lap = 1'b1;
      tick();
    end
    push("full_hold_disp", F_DISP, fd(4, 0, 4));
    check();
    set_sec(9, 9, 9);
    repeat (12) tick();
    push("full_live_disp", F_DISP, fd(9, 9, 9));
    push("full_live_cnt", F_CNT, 21'd4);
    check();

    // 4. recall walk
    for (int k = 0; k < 5; k++) begin
      f_view = 1'b0;
      if (k < 4) begin
        push("rc_idx", F_IDX, 21'(k));
        push("rc_view", F_VIEW, 21'd1);
        push("rc_disp", F_DISP, fd(k + 1, 0, k + 1));
      end else begin
        push("rc_exit_view", F_VIEW, 21'd0);
        push("rc_exit_idx", F_IDX, 21'd0);
        push("rc_exit_disp", F_DISP, fd(9, 9, 9));
      end
      tick();
      check();
      f_view = 1'b1;
      tick();
    end

    // 5. coincident presses in recall
    f_view = 1'b0;
    push("rc5_view", F_VIEW, 21'd1);
    tick();
    check();
    f_view = 1'b1;
    tick();
    f_lap  = 1'b0;
    f_view = 1'b0;
    f_clr  = 1'b0;
    push("co_view", F_VIEW, 21'd0);
    push("co_cnt", F_CNT, 21'd0);
    push("co_full", F_FULL, 21'd0);
    push("co_idx", F_IDX, 21'd0);
    push("co_disp", F_DISP, fd(9, 9, 9));
    tick();
    check();
    f_lap  = 1'b1;
    f_view = 1'b1;
    f_clr  = 1'b1;
    tick();
    push("co_nostore", F_CNT, 21'd0);
    check();

    // 6. held lap, then lap while stopped
    set_sec(2, 5, 8);
    f_lap = 1'b0;
    repeat (50) tick();
    push("held_cnt", F_CNT, 21'd1);
    push("held_view", F_VIEW, 21'd0);
    check();
    f_lap = 1'b1;
    tick();
    f_run = 1'b0;
    set_sec(3, 3, 3);
    f_lap = 1'b0;
    push("stop_cnt", F_CNT, 21'd1);
    push("stop_disp", F_DISP, fd(3, 3, 3));
    tick();
    check();
    f_lap = 1'b1;
    tick();
    f_view = 1'b0;
    push("held_rc_view", F_VIEW, 21'd1);
    push("held_rc_disp", F_DISP, fd(2, 5, 8));
    tick();
    check();
    f_view = 1'b1;
    tick();

    // 7. asynchronous reset while in recall
    #2;
    rst_n = 1'b0;
    #1;
    push("arst_view", F_VIEW, 21'd0);
    push("arst_cnt", F_CNT, 21'd0);
    push("arst_disp", F_DISP, fd(3, 3, 3));
    check();
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
